control_sequencer: RTL and testbench

//  Microcode sequencer for the 8-bit bus computer. It counts T-states and decodes
//  the instruction-register opcode plus the ALU flags into every bus control line.

---
 rtl/ctrl_pkg.sv | 58 +++++
 rtl/control_sequencer_step_button_sync.sv | 50 +++++
 rtl/control_sequencer.sv | 154 +++++++++++++++
 tb/tb_control_sequencer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared constants for the 8-bit bus computer: opcodes, T-states and control-word
// bit positions. The ALU and IR blocks use the same opcode constants.
package ctrl_pkg;

    localparam int MAX_STEP    = 5;
    localparam int STEP_W      = 3;
    localparam int SYNC_STAGES = 2;

    typedef enum logic [STEP_W-1:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4
    } t_state_e;

    localparam logic [STEP_W-1:0] LAST_STEP = 3'(MAX_STEP - 1);

    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_LDA = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_STA = 4'b0100;
    localparam logic [3:0] OP_LDI = 4'b0101;
    localparam logic [3:0] OP_JMP = 4'b0110;
    localparam logic [3:0] OP_JC  = 4'b0111;
    localparam logic [3:0] OP_JZ  = 4'b1000;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    localparam int CW_W        = 16;
    localparam int CW_PC_ENABLE = 0;
    localparam int CW_PC_OUT    = 1;
    localparam int CW_PC_IN     = 2;
    localparam int CW_MAR_IN    = 3;
    localparam int CW_RAM_IN    = 4;
    localparam int CW_RAM_OUT   = 5;
    localparam int CW_IR_IN     = 6;
    localparam int CW_IR_OUT    = 7;
    localparam int CW_A_IN      = 8;
    localparam int CW_A_OUT     = 9;
    localparam int CW_B_IN      = 10;
    localparam int CW_ALU_OUT   = 11;
    localparam int CW_ALU_SUB   = 12;
    localparam int CW_FLAGS_IN  = 13;
    localparam int CW_OUT_IN    = 14;
    localparam int CW_HALT      = 15;

    // Last T-state of each instruction; undefined opcodes behave as NOP.
    function automatic t_state_e final_step(input logic [3:0] op);
        case (op)
            OP_LDA, OP_STA: final_step = T3;
            OP_ADD, OP_SUB: final_step = T4;
            default:        final_step = T2;
        endcase
    endfunction

endpackage

// File: rtl/control_sequencer_step_button_sync.sv
// Debug step button: synchronizer chain plus rising-edge detect on the negedge
// domain, giving a one-cycle step_pulse per press while step mode is active.
module step_button_sync
    import ctrl_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic step_btn,
    input  logic step_mode,
    output logic step_pulse
);

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            logic q_reg;
            if (gi == 0) begin : g_first
                always_ff @(negedge clock or posedge reset) begin
                    if (reset) q_reg <= 1'b0;
                    else       q_reg <= step_btn;
                end
            end else begin : g_rest
                always_ff @(negedge clock or posedge reset) begin
                    if (reset) q_reg <= 1'b0;
                    else       q_reg <= g_sync[gi-1].q_reg;
                end
            end
        end
    endgenerate

    logic btn_sync;
    logic prev_reg;
    logic mode_reg;

    assign btn_sync = g_sync[SYNC_STAGES-1].q_reg;

    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            prev_reg <= 1'b0;
            mode_reg <= 1'b0;
        end else begin
            prev_reg <= btn_sync;
            mode_reg <= step_mode;
        end
    end

    // mode_reg gates out any edge that was in flight when step mode was entered.
    assign step_pulse = step_mode & mode_reg & btn_sync & ~prev_reg;

endmodule

// File: rtl/control_sequencer.sv
// Microcode sequencer: T-state counter and halt latch on negedge, combinational
// decode of {opcode, step, flags, halt} into the bus control lines.
module control_sequencer
    import ctrl_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] opcode,
    input  logic       carry_flag,
    input  logic       zero_flag,
    input  logic       step_mode,
    input  logic       step_btn,
    output logic       pc_enable,
    output logic       pc_out,
    output logic       pc_in,
    output logic       mar_in,
    output logic       ram_in,
    output logic       ram_out,
    output logic       ir_in,
    output logic       ir_out,
    output logic       a_in,
    output logic       a_out,
    output logic       b_in,
    output logic       alu_out,
    output logic       alu_sub,
    output logic       flags_in,
    output logic       out_in,
    output logic       halt,
    output logic [2:0] step
);

    t_state_e        state_reg, state_next;
    logic            halt_reg, halt_next;
    logic            step_pulse;
    logic            advance;
    logic [CW_W-1:0] cw;

    step_button_sync u_step_button_sync (
        .clock      (clock),
        .reset      (reset),
        .step_btn   (step_btn),
        .step_mode  (step_mode),
        .step_pulse (step_pulse)
    );

    assign advance = ~step_mode | step_pulse;

    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= T0;
            halt_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            halt_reg  <= halt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        halt_next  = halt_reg;
        if (!halt_reg && advance) begin
            if (state_reg == T2 && opcode == OP_HLT) begin
                // Step stays frozen at T2 once halted.
                halt_next = 1'b1;
            end else if (state_reg == final_step(opcode) || state_reg == LAST_STEP) begin
                state_next = T0;
            end else begin
                state_next = t_state_e'(state_reg + 3'd1);
            end
        end
    end

    always_comb begin
        cw = '0;
        if (halt_reg) begin
            cw[CW_HALT] = 1'b1;
        end else if (state_reg == T0) begin
            cw[CW_PC_OUT] = 1'b1;
            cw[CW_MAR_IN] = 1'b1;
        end else if (state_reg == T1) begin
            cw[CW_RAM_OUT]   = 1'b1;
            cw[CW_IR_IN]     = 1'b1;
            cw[CW_PC_ENABLE] = 1'b1;
        end else begin
            case ({opcode, state_reg})
                {OP_LDA, T2}, {OP_ADD, T2}, {OP_SUB, T2}, {OP_STA, T2}: begin
                    cw[CW_IR_OUT] = 1'b1;
                    cw[CW_MAR_IN] = 1'b1;
                end
                {OP_LDA, T3}: begin
                    cw[CW_RAM_OUT] = 1'b1;
                    cw[CW_A_IN]    = 1'b1;
                end
                {OP_ADD, T3}, {OP_SUB, T3}: begin
                    cw[CW_RAM_OUT] = 1'b1;
                    cw[CW_B_IN]    = 1'b1;
                end
                {OP_ADD, T4}, {OP_SUB, T4}: begin
                    cw[CW_ALU_OUT]  = 1'b1;
                    cw[CW_A_IN]     = 1'b1;
                    cw[CW_FLAGS_IN] = 1'b1;
                    cw[CW_ALU_SUB]  = (opcode == OP_SUB);
                end
                {OP_STA, T3}: begin
                    cw[CW_A_OUT]  = 1'b1;
                    cw[CW_RAM_IN] = 1'b1;
                end
                {OP_LDI, T2}: begin
                    cw[CW_IR_OUT] = 1'b1;
                    cw[CW_A_IN]   = 1'b1;
                end
                {OP_JMP, T2}: begin
                    cw[CW_IR_OUT] = 1'b1;
                    cw[CW_PC_IN]  = 1'b1;
                end
                {OP_JC, T2}: begin
                    cw[CW_IR_OUT] = carry_flag;
                    cw[CW_PC_IN]  = carry_flag;
                end
                {OP_JZ, T2}: begin
                    cw[CW_IR_OUT] = zero_flag;
                    cw[CW_PC_IN]  = zero_flag;
                end
                {OP_OUT, T2}: begin
                    cw[CW_A_OUT]  = 1'b1;
                    cw[CW_OUT_IN] = 1'b1;
                end
                {OP_HLT, T2}: begin
                    cw[CW_HALT] = 1'b1;
                end
                default: cw = '0;
            endcase
        end
    end

    assign pc_enable = cw[CW_PC_ENABLE];
    assign pc_out    = cw[CW_PC_OUT];
    assign pc_in     = cw[CW_PC_IN];
    assign mar_in    = cw[CW_MAR_IN];
    assign ram_in    = cw[CW_RAM_IN];
    assign ram_out   = cw[CW_RAM_OUT];
    assign ir_in     = cw[CW_IR_IN];
    assign ir_out    = cw[CW_IR_OUT];
    assign a_in      = cw[CW_A_IN];
    assign a_out     = cw[CW_A_OUT];
    assign b_in      = cw[CW_B_IN];
    assign alu_out   = cw[CW_ALU_OUT];
    assign alu_sub   = cw[CW_ALU_SUB];
    assign flags_in  = cw[CW_FLAGS_IN];
    assign out_in    = cw[CW_OUT_IN];
    assign halt      = cw[CW_HALT];
    assign step      = state_reg;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: expected control words are queued as
// stimulus is applied and compared at each posedge (+1) against the DUT.
module tb_control_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] opcode = 4'b0000;
    logic       carry_flag = 1'b0;
    logic       zero_flag = 1'b0;
    logic       step_mode = 1'b0;
    logic       step_btn = 1'b0;
    logic       pc_enable, pc_out, pc_in, mar_in, ram_in, ram_out, ir_in, ir_out;
    logic       a_in, a_out, b_in, alu_out, alu_sub, flags_in, out_in, halt;
    logic [2:0] step;

    control_sequencer dut (
        .clock(clock), .reset(reset), .opcode(opcode), .carry_flag(carry_flag),
        .zero_flag(zero_flag), .step_mode(step_mode), .step_btn(step_btn),
        .pc_enable(pc_enable), .pc_out(pc_out), .pc_in(pc_in), .mar_in(mar_in),
        .ram_in(ram_in), .ram_out(ram_out), .ir_in(ir_in), .ir_out(ir_out),
        .a_in(a_in), .a_out(a_out), .b_in(b_in), .alu_out(alu_out),
        .alu_sub(alu_sub), .flags_in(flags_in), .out_in(out_in), .halt(halt),
        .step(step)
    );

    always #5 clock = ~clock;

    localparam logic [15:0] PC_EN    = 16'h8000, PC_OUT  = 16'h4000, PC_IN    = 16'h2000;
    localparam logic [15:0] MAR_IN   = 16'h1000, RAM_IN  = 16'h0800, RAM_OUT  = 16'h0400;
    localparam logic [15:0] IR_IN    = 16'h0200, IR_OUT  = 16'h0100, A_IN     = 16'h0080;
    localparam logic [15:0] A_OUT    = 16'h0040, B_IN    = 16'h0020, ALU_OUT  = 16'h0010;
    localparam logic [15:0] ALU_SUB  = 16'h0008, FLAGS_IN = 16'h0004, OUT_IN  = 16'h0002;
    localparam logic [15:0] HALT     = 16'h0001;
    localparam logic [15:0] W_T0     = PC_OUT | MAR_IN;
    localparam logic [15:0] W_T1     = RAM_OUT | IR_IN | PC_EN;

    logic [15:0] obs_cw;
    assign obs_cw = {pc_enable, pc_out, pc_in, mar_in, ram_in, ram_out, ir_in, ir_out,
                     a_in, a_out, b_in, alu_out, alu_sub, flags_in, out_in, halt};

    typedef struct {
        string      tag;
        logic [15:0] cw;
        logic [2:0]  st;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic push(input string tag, input logic [15:0] cw, input logic [2:0] st);
        exp_t e;
        e.tag = tag;
        e.cw  = cw;
        e.st  = st;
        sb.push_back(e);
    endtask

    task automatic compare_front();
        exp_t e;
        e = sb.pop_front();
        checks++;
        assert (obs_cw === e.cw) else begin
            errors++;
            $error("FAIL %s ctrl: observed=%h expected=%h", e.tag, obs_cw, e.cw);
        end
        checks++;
        assert (step === e.st) else begin
            errors++;
            $error("FAIL %s step: observed=%0d expected=%0d", e.tag, step, e.st);
        end
        $display("t=%0t %s step=%0d ctrl=%h", $time, e.tag, step, obs_cw);
    endtask

    task automatic check_next();
        @(posedge clock);
        #1;
        compare_front();
    endtask

    task automatic drain();
        while (sb.size() > 0) check_next();
    endtask

    // Leaves the bench at negedge+1 with step freshly back at T0.
    task automatic next_instr();
        @(negedge clock);
        #1;
    endtask

    task automatic load(input logic [3:0] op, input logic c, input logic z);
        opcode     = op;
        carry_flag = c;
        zero_flag  = z;
    endtask

    task automatic fetch(input string name);
        push({name, "_T0"}, W_T0, 3'd0);
        push({name, "_T1"}, W_T1, 3'd1);
    endtask

    task automatic apply_reset(input string name);
        reset = 1'b1;
        #1;
        push(name, W_T0, 3'd0);
        compare_front();
        @(negedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #1;
        apply_reset("reset_init");

        load(4'b0001, 1'b0, 1'b0);
        fetch("lda");
        push("lda_T2", IR_OUT | MAR_IN, 3'd2);
        push("lda_T3", RAM_OUT | A_IN, 3'd3);
        drain();
        next_instr();

        load(4'b0011, 1'b0, 1'b0);
        fetch("sub");
        push("sub_T2", IR_OUT | MAR_IN, 3'd2);
        push("sub_T3", RAM_OUT | B_IN, 3'd3);
        push("sub_T4", ALU_OUT | A_IN | ALU_SUB | FLAGS_IN, 3'd4);
        drain();
        next_instr();

        load(4'b0010, 1'b1, 1'b1);
        fetch("add");
        push("add_T2", IR_OUT | MAR_IN, 3'd2);
        push("add_T3", RAM_OUT | B_IN, 3'd3);
        push("add_T4", ALU_OUT | A_IN | FLAGS_IN, 3'd4);
        drain();
        next_instr();

        load(4'b0111, 1'b0, 1'b1);
        fetch("jc0");
        push("jc0_T2", 16'h0000, 3'd2);
        drain();
        next_instr();

        load(4'b0111, 1'b1, 1'b0);
        fetch("jc1");
        push("jc1_T2", IR_OUT | PC_IN, 3'd2);
        drain();
        next_instr();

        load(4'b1000, 1'b1, 1'b0);
        fetch("jz0");
        push("jz0_T2", 16'h0000, 3'd2);
        drain();
        next_instr();

        load(4'b1000, 1'b0, 1'b1);
        fetch("jz1");
        push("jz1_T2", IR_OUT | PC_IN, 3'd2);
        drain();
        next_instr();

        load(4'b0100, 1'b0, 1'b0);
        fetch("sta");
        push("sta_T2", IR_OUT | MAR_IN, 3'd2);
        push("sta_T3", A_OUT | RAM_IN, 3'd3);
        drain();
        next_instr();

        load(4'b1110, 1'b0, 1'b0);
        fetch("out");
        push("out_T2", A_OUT | OUT_IN, 3'd2);
        drain();
        next_instr();

        load(4'b1010, 1'b1, 1'b1);
        fetch("undef");
        push("undef_T2", 16'h0000, 3'd2);
        drain();
        next_instr();

        load(4'b0101, 1'b0, 1'b0);
        fetch("ldi");
        push("ldi_T2", IR_OUT | A_IN, 3'd2);
        drain();
        next_instr();

        load(4'b1111, 1'b0, 1'b0);
        fetch("hlt");
        push("hlt_T2", HALT, 3'd2);
        drain();
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            #1;
            opcode   = (i % 2 == 0) ? 4'b0010 : 4'b0110;
            step_btn = ~step_btn;
            push("halted", HALT, 3'd2);
            check_next();
        end
        step_btn = 1'b0;
        apply_reset("reset_halt");

        load(4'b0010, 1'b0, 1'b0);
        fetch("add_rst");
        push("add_rst_T2", IR_OUT | MAR_IN, 3'd2);
        push("add_rst_T3", RAM_OUT | B_IN, 3'd3);
        drain();
        #2;
        apply_reset("reset_mid_T3");

        step_mode = 1'b1;
        load(4'b0001, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            push("sm_idle", W_T0, 3'd0);
            check_next();
        end
        step_btn = 1'b1;
        repeat (50) @(posedge clock);
        #1;
        push("sm_press1_held", W_T1, 3'd1);
        compare_front();
        step_btn = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        push("sm_released", W_T1, 3'd1);
        compare_front();
        step_btn = 1'b1;
        repeat (10) @(posedge clock);
        #1;
        push("sm_press2_held", IR_OUT | MAR_IN, 3'd2);
        compare_front();
        step_btn = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
